// File: rtl/iterative_comparator_unit_pkg.sv
// Shared definitions for the iterative branch comparator: op encodings, FSM states, result helpers.
package iterative_comparator_unit_pkg;

    localparam logic [2:0] CMP_OP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_OP_BNE  = 3'b001;
    localparam logic [2:0] CMP_OP_BLT  = 3'b100;
    localparam logic [2:0] CMP_OP_BGE  = 3'b101;
    localparam logic [2:0] CMP_OP_BLTU = 3'b110;
    localparam logic [2:0] CMP_OP_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPARE = 2'b01,
        DONE    = 2'b10
    } cmp_state_t;

    function automatic logic cmp_op_known(input logic [2:0] op);
        case (op)
            CMP_OP_BEQ, CMP_OP_BNE, CMP_OP_BLT,
            CMP_OP_BGE, CMP_OP_BLTU, CMP_OP_BGEU: cmp_op_known = 1'b1;
            default:                              cmp_op_known = 1'b0;
        endcase
    endfunction

    function automatic logic cmp_op_signed(input logic [2:0] op);
        case (op)
            CMP_OP_BLT, CMP_OP_BGE: cmp_op_signed = 1'b1;
            default:                cmp_op_signed = 1'b0;
        endcase
    endfunction

    function automatic logic cmp_result(input logic [2:0] op, input logic lt, input logic eq);
        case (op)
            CMP_OP_BEQ:               cmp_result = eq;
            CMP_OP_BNE:               cmp_result = !eq;
            CMP_OP_BLT, CMP_OP_BLTU:  cmp_result = lt;
            CMP_OP_BGE, CMP_OP_BGEU:  cmp_result = !lt;
            default:                  cmp_result = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/iterative_comparator_unit_cmp_slice.sv
// Combinational unsigned compare of one CHUNK_WIDTH-bit operand slice.
module iterative_comparator_unit_cmp_slice #(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] slice_a,
    input  logic [CHUNK_WIDTH-1:0] slice_b,
    output logic                   slice_lt,
    output logic                   slice_eq
);

    assign slice_lt = (slice_a < slice_b);
    assign slice_eq = (slice_a == slice_b);

endmodule

// File: rtl/iterative_comparator_unit.sv
// Multi-cycle MSB-first branch comparator, CHUNK_WIDTH bits per cycle.
// Optional macro CMP_EARLY_EXIT_EN finishes at the first differing slice.
module iterative_comparator_unit
    import iterative_comparator_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_Flush,
    input  logic            i_Valid,
    output logic            o_Ready,
    input  logic [XLEN-1:0] i_Input_A,
    input  logic [XLEN-1:0] i_Input_B,
    input  logic [2:0]      i_Compare_Select,
    output logic            o_Valid,
    input  logic            i_Ready,
    output logic            o_Cmp_Result,
    output logic            o_Lt,
    output logic            o_Eq
);

    localparam int NUM_SLICES = XLEN / CHUNK_WIDTH;
    localparam int IDX_W      = $clog2(NUM_SLICES) + 1;
    localparam int SEL_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLICES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [XLEN-1:0]  SIGN_MASK = {1'b1, {(XLEN-1){1'b0}}};

    if ((XLEN % CHUNK_WIDTH) != 0) begin : g_bad_width
        $error("XLEN must be a multiple of CHUNK_WIDTH");
    end

    cmp_state_t                                state_r;
    logic [XLEN-1:0]                           a_r;
    logic [XLEN-1:0]                           b_r;
    logic [2:0]                                op_r;
    logic [IDX_W-1:0]                          idx_r;
    logic                                      lt_r;
    logic                                      eq_r;
    logic [NUM_SLICES-1:0][CHUNK_WIDTH-1:0]    a_slices_s;
    logic [NUM_SLICES-1:0][CHUNK_WIDTH-1:0]    b_slices_s;
    logic [SEL_W-1:0]                          sel_s;
    logic                                      slice_lt_s;
    logic                                      slice_eq_s;
    logic                                      next_lt_s;
    logic                                      next_eq_s;
    logic                                      finish_s;

    assign a_slices_s = a_r;
    assign b_slices_s = b_r;
    assign sel_s      = idx_r[SEL_W-1:0];

    iterative_comparator_unit_cmp_slice #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_cmp_slice (
        .slice_a  (a_slices_s[sel_s]),
        .slice_b  (b_slices_s[sel_s]),
        .slice_lt (slice_lt_s),
        .slice_eq (slice_eq_s)
    );

    // First differing slice from the MSB fixes lt/eq; later slices cannot change them.
    always_comb begin
        next_lt_s = lt_r;
        next_eq_s = eq_r;
        if (eq_r && !slice_eq_s) begin
            next_lt_s = slice_lt_s;
            next_eq_s = 1'b0;
        end else begin
            next_lt_s = lt_r;
            next_eq_s = eq_r;
        end
    end

`ifdef CMP_EARLY_EXIT_EN
    assign finish_s = (idx_r == '0) || (eq_r && !slice_eq_s);
`else
    assign finish_s = (idx_r == '0);
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_r      <= IDLE;
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= 3'b000;
            idx_r        <= '0;
            lt_r         <= 1'b0;
            eq_r         <= 1'b1;
            o_Ready      <= 1'b1;
            o_Valid      <= 1'b0;
            o_Cmp_Result <= 1'b0;
            o_Lt         <= 1'b0;
            o_Eq         <= 1'b0;
        end else if (i_Flush) begin
            state_r <= IDLE;
            o_Ready <= 1'b1;
            o_Valid <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_Valid) begin
                        // Flipping the sign bit turns a signed compare into an unsigned one.
                        a_r     <= cmp_op_signed(i_Compare_Select) ? (i_Input_A ^ SIGN_MASK) : i_Input_A;
                        b_r     <= cmp_op_signed(i_Compare_Select) ? (i_Input_B ^ SIGN_MASK) : i_Input_B;
                        op_r    <= i_Compare_Select;
                        idx_r   <= IDX_LAST;
                        lt_r    <= 1'b0;
                        eq_r    <= 1'b1;
                        o_Ready <= 1'b0;
                        state_r <= COMPARE;
                    end
                end
                COMPARE: begin
                    lt_r <= next_lt_s;
                    eq_r <= next_eq_s;
                    if (finish_s) begin
                        o_Valid      <= 1'b1;
                        o_Cmp_Result <= cmp_result(op_r, next_lt_s, next_eq_s);
                        o_Lt         <= cmp_op_known(op_r) ? next_lt_s : 1'b0;
                        o_Eq         <= next_eq_s;
                        state_r      <= DONE;
                    end else begin
                        idx_r <= idx_r - IDX_ONE;
                    end
                end
                DONE: begin
                    if (i_Ready) begin
                        o_Valid <= 1'b0;
                        o_Ready <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    o_Ready <= 1'b1;
                    o_Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_comparator_unit.sv
// Self-checking bench for iterative_comparator_unit against a behavioural branch-compare model.
module tb_iterative_comparator_unit;
    import iterative_comparator_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int CW   = 8;
    localparam int NS   = XLEN / CW;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            out_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      sel;
    logic            out_valid;
    logic            in_ready;
    logic            res;
    logic            lt;
    logic            eq;

    int checks = 0;
    int errors = 0;

    iterative_comparator_unit #(.XLEN(XLEN), .CHUNK_WIDTH(CW)) dut (
        .i_Clk            (clk),
        .i_Reset          (rst),
        .i_Flush          (flush),
        .i_Valid          (in_valid),
        .o_Ready          (out_ready),
        .i_Input_A        (in_a),
        .i_Input_B        (in_b),
        .i_Compare_Select (sel),
        .o_Valid          (out_valid),
        .i_Ready          (in_ready),
        .o_Cmp_Result     (res),
        .o_Lt             (lt),
        .o_Eq             (eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width arithmetic, latency from the position of the highest differing slice.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] op,
                                  output logic r, output logic l, output logic e, output int lat);
        logic [31:0] mask;
        logic        found;
        e = (ma == mb);
        case (op)
            CMP_OP_BLT, CMP_OP_BGE:                         l = ($signed(ma) < $signed(mb));
            CMP_OP_BEQ, CMP_OP_BNE, CMP_OP_BLTU, CMP_OP_BGEU: l = (ma < mb);
            default:                                        l = 1'b0;
        endcase
        case (op)
            CMP_OP_BEQ:              r = e;
            CMP_OP_BNE:              r = !e;
            CMP_OP_BLT, CMP_OP_BLTU: r = l;
            CMP_OP_BGE, CMP_OP_BGEU: r = !l;
            default:                 r = 1'b0;
        endcase
        lat   = NS;
        mask  = (32'h1 << CW) - 32'h1;
        found = 1'b0;
`ifdef CMP_EARLY_EXIT_EN
        for (int s = NS - 1; s >= 0; s--) begin
            if (!found && (((ma >> (s * CW)) & mask) != ((mb >> (s * CW)) & mask))) begin
                lat   = NS - s;
                found = 1'b1;
            end
        end
`endif
    endfunction

    task automatic start(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] op, input string tag);
        check({tag, "_ready_before"}, {31'd0, out_ready}, 32'd1);
        in_a     = ta;
        in_b     = tb;
        sel      = op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        sel      = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (out_valid !== 1'b1 && cnt < 40);
    endtask

    task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] op, input string tag);
        logic er, el, ee;
        int   elat, cnt;
        model(ta, tb, op, er, el, ee, elat);
        start(ta, tb, op, tag);
        wait_valid(cnt);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_latency"}, cnt, elat);
        check({tag, "_result"}, {31'd0, res}, {31'd0, er});
        check({tag, "_lt"}, {31'd0, lt}, {31'd0, el});
        check({tag, "_eq"}, {31'd0, eq}, {31'd0, ee});
        check({tag, "_ready_done"}, {31'd0, out_ready}, 32'd0);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check({tag, "_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_after_hs"}, {31'd0, out_ready}, 32'd1);
    endtask

    initial begin
        int          cnt;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        in_a = '0; in_b = '0; sel = 3'b000;
        tick();
        tick();
        check("reset_ready", {31'd0, out_ready}, 32'd1);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", {31'd0, res}, 32'd0);
        check("reset_lt", {31'd0, lt}, 32'd0);
        check("reset_eq", {31'd0, eq}, 32'd0);
        rst = 1'b0;
        tick();

        run(32'h0000_0001, 32'hFFFF_FFFF, CMP_OP_BLTU, "bltu");
        run(32'hFFFF_FFFF, 32'h0000_0001, CMP_OP_BLT, "blt_neg");
        run(32'hFFFF_FFFF, 32'h0000_0001, CMP_OP_BGE, "bge_neg");
        run(32'hFFFF_FFFF, 32'h0000_0001, CMP_OP_BGEU, "bgeu");
        run(32'hDEAD_BEEF, 32'hDEAD_BEEF, CMP_OP_BEQ, "beq");
        run(32'hDEAD_BEEE, 32'hDEAD_BEEF, CMP_OP_BNE, "bne_last");
        run(32'h8000_0000, 32'h7FFF_FFFF, CMP_OP_BLT, "blt_minmax");
        run(32'h1234_5678, 32'h1234_5678, 3'b010, "unknown_op");

        // Backpressure: result holds, new requests ignored while waiting for the consumer.
        start(32'h0102_0304, 32'h0102_0305, CMP_OP_BLTU, "bp");
        wait_valid(cnt);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            sel      = CMP_OP_BGEU;
            tick();
            check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
            check("bp_ready_low", {31'd0, out_ready}, 32'd0);
            check("bp_result_hold", {31'd0, res}, 32'd1);
            check("bp_lt_hold", {31'd0, lt}, 32'd1);
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check("bp_ready_after", {31'd0, out_ready}, 32'd1);
        check("bp_valid_after", {31'd0, out_valid}, 32'd0);
        repeat (NS + 2) tick();
        check("bp_no_ghost", {31'd0, out_valid}, 32'd0);

        // Flush during COMPARE discards the operation.
        start(32'hAAAA_5555, 32'hAAAA_5555, CMP_OP_BEQ, "flush_cmp");
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_cmp_valid", {31'd0, out_valid}, 32'd0);
        check("flush_cmp_ready", {31'd0, out_ready}, 32'd1);
        repeat (NS + 2) tick();
        check("flush_cmp_no_result", {31'd0, out_valid}, 32'd0);

        // Flush in DONE wins over a simultaneous result handshake.
        start(32'h0000_0010, 32'h0000_0020, CMP_OP_BLTU, "flush_done");
        wait_valid(cnt);
        check("flush_done_reached", {31'd0, out_valid}, 32'd1);
        flush    = 1'b1;
        in_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_ready = 1'b0;
        check("flush_done_valid", {31'd0, out_valid}, 32'd0);
        check("flush_done_ready", {31'd0, out_ready}, 32'd1);

        // Flush in IDLE wins over a simultaneous accept.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = 32'h5;
        in_b     = 32'h5;
        sel      = CMP_OP_BEQ;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_not_accepted", {31'd0, out_ready}, 32'd1);
        repeat (NS + 2) tick();
        check("flush_idle_no_result", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-COMPARE.
        start(32'h3333_3333, 32'h3333_3333, CMP_OP_BEQ, "rst_mid");
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_ready", {31'd0, out_ready}, 32'd1);
        #2;
        rst = 1'b0;
        repeat (NS + 2) tick();
        check("rst_mid_no_result", {31'd0, out_valid}, 32'd0);
        run(32'h0000_0002, 32'h0000_0001, CMP_OP_BGEU, "after_rst");

        // Randomized operations, biased toward equal and single-slice-different operands.
        for (int n = 0; n < 40; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = rb;
            endcase
            run(ra, rb, rop, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
